// File: rtl/sample_framer_pkg.sv
// rtl/sample_framer_pkg.sv - shared types and default parameters for the sample framer
// Contents: state_t (IDLE, STREAM, WAIT_DONE); DEF_WIDTH, DEF_DEPTH, DEF_FRAME_LEN defaults.
package sample_framer_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_FRAME_LEN = 20;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sample_framer_if.sv
// rtl/sample_framer_if.sv - sample stream bundle between upstream source, framer and downstream sink
// Signals: in_data/in_valid/in_ready (upstream push side), out_data/valid_signal (downstream side).
// Modports: master = testbench/upstream driver, slave = framer.
interface sample_framer_if
  import sample_framer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             valid_signal;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  out_data,
    input  valid_signal
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output out_data,
    output valid_signal
  );

endinterface

// File: rtl/sample_framer_sync_fifo.sv
// rtl/sample_framer_sync_fifo.sv - DEPTH-entry synchronous FIFO with occupancy count
// Ports: clock, reset (sync, active-high), push/push_data, pop/pop_data (show-ahead), count (0..DEPTH).
module sync_fifo
  import sample_framer_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Gating on the registered count means a push into an empty FIFO is not
  // visible to a pop in the same cycle; the entry becomes poppable next cycle.
  assign do_push  = push && (count != CW'(DEPTH));
  assign do_pop   = pop && (count != '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_framer.sv
// rtl/sample_framer.sv - buffers upstream samples and issues FRAME_LEN-sample frames on start
// Ports: clock, reset (sync, active-high), bus (sample_framer_if.slave: in_data/in_valid/in_ready,
//   out_data/valid_signal), start, done_signal, frame_done, busy.
// Option: SAMPLE_FRAMER_STATS_EN adds frame_cnt (wrapping) and drop_cnt (saturating) outputs.
module sample_framer
  import sample_framer_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN
) (
  input  logic            clock,
  input  logic            reset,
  sample_framer_if.slave  bus,
  input  logic            start,
  input  logic            done_signal,
  output logic            frame_done,
  output logic            busy
`ifdef SAMPLE_FRAMER_STATS_EN
  ,
  output logic [7:0]      frame_cnt,
  output logic [7:0]      drop_cnt
`endif
);

  localparam int              CW       = $clog2(DEPTH) + 1;
  localparam logic [4:0]      LAST_IDX = 5'(FRAME_LEN - 1);
  localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

  state_t           state;
  logic [4:0]       sample_cnt;
  logic [WIDTH-1:0] out_data_q;
  logic             valid_q;

  logic [CW-1:0]    fifo_count;
  logic [WIDTH-1:0] pop_data;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  assign fifo_empty       = (fifo_count == '0);
  assign fifo_full        = (fifo_count == FULL_CNT);
  assign bus.in_ready     = !fifo_full;
  assign push             = bus.in_valid && !fifo_full;
  assign pop              = (state == STREAM) && !fifo_empty;
  assign bus.out_data     = out_data_q;
  assign bus.valid_signal = valid_q;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (bus.in_data),
    .pop       (pop),
    .pop_data  (pop_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      sample_cnt <= '0;
      out_data_q <= '0;
      valid_q    <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid_q    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= STREAM;
            busy  <= 1'b1;
          end
        end
        STREAM: begin
          // out_data holds its last value across empty-FIFO gaps.
          if (pop) begin
            out_data_q <= pop_data;
            valid_q    <= 1'b1;
            if (sample_cnt == LAST_IDX) begin
              sample_cnt <= '0;
              state      <= WAIT_DONE;
            end else begin
              sample_cnt <= sample_cnt + 5'd1;
            end
          end
        end
        WAIT_DONE: begin
          if (done_signal) begin
            state      <= IDLE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SAMPLE_FRAMER_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      frame_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (state == WAIT_DONE && done_signal) begin
        frame_cnt <= frame_cnt + 8'd1;
      end
      if (bus.in_valid && fifo_full && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sample_framer.sv
// tb/tb_sample_framer.sv - directed self-checking bench for sample_framer
module tb_sample_framer;
  import sample_framer_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic done_signal = 1'b0;
  logic frame_done;
  logic busy;
`ifdef SAMPLE_FRAMER_STATS_EN
  logic [7:0] frame_cnt;
  logic [7:0] drop_cnt;
`endif

  int checks = 0;
  int failures = 0;

  sample_framer_if #(.WIDTH(8)) bus ();

  sample_framer #(.WIDTH(8), .DEPTH(8), .FRAME_LEN(20)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus.slave),
    .start       (start),
    .done_signal (done_signal),
    .frame_done  (frame_done),
    .busy        (busy)
`ifdef SAMPLE_FRAMER_STATS_EN
    ,
    .frame_cnt   (frame_cnt),
    .drop_cnt    (drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    done_signal = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.valid_signal !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid_signal); end
    checks++; if (bus.out_data !== 8'd0) begin failures++; $display("FAIL reset_out_data got=%0d exp=0", bus.out_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
`ifdef SAMPLE_FRAMER_STATS_EN
    checks++; if (frame_cnt !== 8'd0 || drop_cnt !== 8'd0) begin failures++; $display("FAIL reset_stats frame_cnt=%0d drop_cnt=%0d exp=0/0", frame_cnt, drop_cnt); end
`endif
  endtask

  // 20 samples 1..20 streamed through the 8-deep FIFO while the frame runs.
  task automatic test_frame();
    int sent = 1;
    int got = 0;
    int fd_seen = 0;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sent <= 20 && bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'(sent);
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.in_valid) sent++;
      if (frame_done) fd_seen++;
      if (bus.valid_signal) begin
        got++;
        checks++;
        if (bus.out_data !== 8'(got)) begin failures++; $display("FAIL frame_data idx=%0d got=%0d exp=%0d", got, bus.out_data, got); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 20) begin failures++; $display("FAIL frame_valid_count got=%0d exp=20", got); end
    checks++; if (dut.state !== WAIT_DONE) begin failures++; $display("FAIL frame_state got=%0d exp=%0d", dut.state, WAIT_DONE); end
    checks++; if (fd_seen != 0) begin failures++; $display("FAIL frame_done_early got=%0d exp=0", fd_seen); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL frame_busy got=%b exp=1", busy); end
  endtask

  // Continues from the WAIT_DONE state left by test_frame.
  task automatic test_done();
    done_signal = 1'b1;
    step();
    done_signal = 1'b0;
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL done_pulse got=%b exp=1", frame_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL done_busy got=%b exp=0", busy); end
`ifdef SAMPLE_FRAMER_STATS_EN
    checks++; if (frame_cnt !== 8'd1) begin failures++; $display("FAIL done_frame_cnt got=%0d exp=1", frame_cnt); end
`endif
    step();
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL done_pulse_width got=%b exp=0", frame_done); end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b1 || dut.state !== STREAM) begin failures++; $display("FAIL done_restart busy=%b state=%0d exp=1/%0d", busy, dut.state, STREAM); end
  endtask

  task automatic test_overflow();
    int got = 0;
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
      step();
      if (i == 7) begin
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL ovf_ready7 got=%b exp=1", bus.in_ready); end
      end
      if (i == 8) begin
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL ovf_ready8 got=%b exp=0", bus.in_ready); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (dut.u_fifo.count !== 4'd8) begin failures++; $display("FAIL ovf_count got=%0d exp=8", dut.u_fifo.count); end
`ifdef SAMPLE_FRAMER_STATS_EN
    checks++; if (drop_cnt !== 8'd1) begin failures++; $display("FAIL ovf_drop_cnt got=%0d exp=1", drop_cnt); end
`endif
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (bus.valid_signal) begin
        got++;
        checks++;
        if (bus.out_data !== 8'(got)) begin failures++; $display("FAIL ovf_data idx=%0d got=%0d exp=%0d", got, bus.out_data, got); end
      end
    end
    checks++; if (got != 8) begin failures++; $display("FAIL ovf_drained got=%0d exp=8", got); end
  endtask

  task automatic test_trickle();
    int got = 0;
    int k = 1;
    int back_to_back = 0;
    logic prev_valid = 1'b0;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 90; c++) begin
      if (c % 3 == 0 && k <= 25) begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'(k);
        k++;
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.valid_signal) begin
        got++;
        if (prev_valid) back_to_back++;
        checks++;
        if (bus.out_data !== 8'(got)) begin failures++; $display("FAIL trickle_data idx=%0d got=%0d exp=%0d", got, bus.out_data, got); end
      end
      prev_valid = bus.valid_signal;
      checks++;
      if (dut.sample_cnt !== 5'(got % 20)) begin failures++; $display("FAIL trickle_counter cyc=%0d got=%0d exp=%0d", c, dut.sample_cnt, got % 20); end
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 20) begin failures++; $display("FAIL trickle_valid_count got=%0d exp=20", got); end
    checks++; if (back_to_back != 0) begin failures++; $display("FAIL trickle_gaps got=%0d exp=0", back_to_back); end
    checks++; if (dut.state !== WAIT_DONE) begin failures++; $display("FAIL trickle_state got=%0d exp=%0d", dut.state, WAIT_DONE); end
  endtask

  task automatic test_reset_mid();
    int sent = 1;
    int got = 0;
    int first = -1;
    do_reset();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 30 && got < 7; c++) begin
      if (bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'(sent);
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.in_valid) sent++;
      if (bus.valid_signal) got++;
    end
    checks++; if (got != 7) begin failures++; $display("FAIL mid_reached7 got=%0d exp=7", got); end
    bus.in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (bus.valid_signal !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", bus.valid_signal); end
    checks++; if (dut.u_fifo.count !== 4'd0) begin failures++; $display("FAIL mid_fifo_empty got=%0d exp=0", dut.u_fifo.count); end
    checks++; if (dut.sample_cnt !== 5'd0) begin failures++; $display("FAIL mid_counter got=%0d exp=0", dut.sample_cnt); end
    step();
    checks++; if (frame_done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_no_done frame_done=%b busy=%b exp=0/0", frame_done, busy); end
    got = 0;
    sent = 1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sent <= 20 && bus.in_ready) begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'(100 + sent);
      end else begin
        bus.in_valid = 1'b0;
      end
      step();
      if (bus.in_valid) sent++;
      if (bus.valid_signal) begin
        got++;
        if (first < 0) first = int'(bus.out_data);
      end
      if (got == 19) begin
        checks++;
        if (dut.state !== STREAM) begin failures++; $display("FAIL mid_restart_19 state=%0d exp=%0d", dut.state, STREAM); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (first != 101) begin failures++; $display("FAIL mid_restart_first got=%0d exp=101", first); end
    checks++; if (got != 20 || dut.state !== WAIT_DONE) begin failures++; $display("FAIL mid_restart_frame got=%0d state=%0d exp=20/%0d", got, dut.state, WAIT_DONE); end
  endtask

  // Steady push+pop at occupancy 4 walks both pointers past the wrap point.
  task automatic test_wrap();
    int got = 0;
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
      step();
    end
    bus.in_valid = 1'b0;
    checks++; if (dut.u_fifo.count !== 4'd4) begin failures++; $display("FAIL wrap_fill got=%0d exp=4", dut.u_fifo.count); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(5 + c);
      step();
      checks++;
      if (dut.u_fifo.count !== 4'd4) begin failures++; $display("FAIL wrap_count cyc=%0d got=%0d exp=4", c, dut.u_fifo.count); end
      if (bus.valid_signal) begin
        got++;
        checks++;
        if (bus.out_data !== 8'(got)) begin failures++; $display("FAIL wrap_data idx=%0d got=%0d exp=%0d", got, bus.out_data, got); end
      end
    end
    bus.in_valid = 1'b0;
    checks++; if (got != 12) begin failures++; $display("FAIL wrap_valid_count got=%0d exp=12", got); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    test_reset();
    test_frame();
    test_done();
    test_overflow();
    test_trickle();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
